// File: rtl/rmii_phy_tx_pkg.sv
// Shared constants, state encoding and sizing helper for the PHY-side RMII transmitter
// and the dibit strobe divider it shares with the receive side.
package rmii_phy_tx_pkg;

  localparam int unsigned DEF_PREAMBLE_BYTES = 7;
  localparam int unsigned DEF_IFG_BYTES      = 12;
  localparam int unsigned DEF_DIV_10M        = 10;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DRAIN,
    ST_IFG
  } tx_state_e;

  // Counter width for a count of `limit` values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rmii_dibit_strobe.sv
// Dibit-rate strobe: every clock at 100 Mb/s, once per DIV_10M clocks at 10 Mb/s.
// The strobe is high during the final clock of each dibit period.
module rmii_dibit_strobe
  import rmii_phy_tx_pkg::*;
#(
  parameter int unsigned DIV_10M = DEF_DIV_10M
) (
  input  logic clk,
  input  logic rst,
  input  logic speed_100,
  input  logic restart,
  output logic strobe
);

  localparam int unsigned CNT_W = cnt_w(DIV_10M);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_10M - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  // Restart aligns the next dibit period to the clock after the restart request.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    strobe_d = speed_100 || (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/rmii_phy_tx.sv
// PHY-side RMII transmitter: presents an AXI-stream frame to a MAC as CRS_DV/RXD/RX_ER,
// adding preamble/SFD, flagging errors and underflows, and enforcing the inter-frame gap.
module rmii_phy_tx
  import rmii_phy_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = DEF_PREAMBLE_BYTES,
  parameter int unsigned IFG_BYTES      = DEF_IFG_BYTES,
  parameter int unsigned DIV_10M        = DEF_DIV_10M
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  input  logic       speed_100,
  output logic       rmii_crsdv,
  output logic [1:0] rmii_rxd,
  output logic       rmii_rxer,
  output logic       busy,
  output logic       stat_underflow
);

  // Preamble bytes plus the SFD byte, in dibits.
  localparam int unsigned PRE_DIBITS = (PREAMBLE_BYTES + 1) * 4;
  localparam int unsigned PRE_W      = cnt_w(PRE_DIBITS);
  localparam int unsigned IFG_DIBITS = IFG_BYTES * 4;
  localparam int unsigned IFG_W      = cnt_w(IFG_DIBITS);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRE_DIBITS - 1);
  localparam logic [PRE_W-1:0] PRE_BEFORE = PRE_W'(PRE_DIBITS - 2);
  localparam logic [IFG_W-1:0] IFG_LAST   = IFG_W'(IFG_DIBITS - 1);

  tx_state_e        state_q, state_d;
  logic [1:0]       dib_q, dib_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [7:0]       sh_q, sh_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             uf_q, uf_d;
  logic             tl_seen_q, tl_seen_d;
  logic             speed_q, speed_d;
  logic             crsdv_q, crsdv_d;
  logic [1:0]       rxd_q, rxd_d;
  logic             rxer_q, rxer_d;
  logic             ufl_q, ufl_d;

  logic strobe;
  logic fetch_c;
  logic tready_c;
  logic accept_c;
  logic start_c;
  logic restart_c;
  logic strobe_speed_c;

  // Fetch clock: final clock of the SFD or of a non-final data byte.
  assign fetch_c = strobe &&
                   (((state_q == ST_PREAMBLE) && (pre_q == PRE_LAST)) ||
                    ((state_q == ST_DATA) && !uf_q && (dib_q == 2'd3) && !last_q));

  // During the underflow byte the source is already being drained, until its tlast is taken.
  assign tready_c = fetch_c ||
                    (state_q == ST_DRAIN) ||
                    ((state_q == ST_DATA) && uf_q && !tl_seen_q);

  assign accept_c = tready_c && s_axis_tvalid;

  // A frame may start from IDLE, or on the very strobe that completes the gap.
  assign start_c = s_axis_tvalid &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_IFG) && strobe && (ifg_q == IFG_LAST)));

  assign restart_c      = start_c || (state_q == ST_IDLE);
  assign strobe_speed_c = ((state_q == ST_IDLE) || start_c) ? speed_100 : speed_q;

  rmii_dibit_strobe #(
    .DIV_10M (DIV_10M)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .speed_100 (strobe_speed_c),
    .restart   (restart_c),
    .strobe    (strobe)
  );

  // Next-state and next-output logic; outputs only move on a strobe.
  always_comb begin
    state_d   = state_q;
    dib_d     = dib_q;
    pre_d     = pre_q;
    ifg_d     = ifg_q;
    sh_d      = sh_q;
    last_d    = last_q;
    err_d     = err_q;
    uf_d      = uf_q;
    tl_seen_d = tl_seen_q;
    speed_d   = speed_q;
    crsdv_d   = crsdv_q;
    rxd_d     = rxd_q;
    rxer_d    = rxer_q;
    ufl_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        crsdv_d = 1'b0;
        rxd_d   = 2'b00;
        rxer_d  = 1'b0;
      end

      ST_PREAMBLE: begin
        if (strobe && (pre_q != PRE_LAST)) begin
          pre_d = pre_q + PRE_W'(1);
          rxd_d = (pre_q == PRE_BEFORE) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
        end
      end

      ST_DATA: begin
        if (uf_q) begin
          if (accept_c && s_axis_tlast) begin
            tl_seen_d = 1'b1;
          end
          if (strobe) begin
            if (dib_q == 2'd3) begin
              ufl_d     = 1'b1;
              uf_d      = 1'b0;
              tl_seen_d = 1'b0;
              crsdv_d   = 1'b0;
              rxd_d     = 2'b00;
              rxer_d    = 1'b0;
              ifg_d     = '0;
              state_d   = (tl_seen_q || (accept_c && s_axis_tlast)) ? ST_IFG : ST_DRAIN;
            end else begin
              dib_d = dib_q + 2'd1;
            end
          end
        end else if (strobe) begin
          if (dib_q != 2'd3) begin
            dib_d = dib_q + 2'd1;
            rxd_d = sh_q[1:0];
            sh_d  = {2'b00, sh_q[7:2]};
          end else if (last_q) begin
            state_d = ST_IFG;
            ifg_d   = '0;
            crsdv_d = 1'b0;
            rxd_d   = 2'b00;
            rxer_d  = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (accept_c && s_axis_tlast) begin
          state_d = ST_IFG;
          ifg_d   = '0;
        end
      end

      ST_IFG: begin
        if (strobe) begin
          if (ifg_q == IFG_LAST) begin
            state_d = ST_IDLE;
          end else begin
            ifg_d = ifg_q + IFG_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Byte fetch: load the next byte, or start the one-byte underflow marker.
    if (fetch_c) begin
      state_d = ST_DATA;
      dib_d   = 2'd0;
      crsdv_d = 1'b1;
      if (s_axis_tvalid) begin
        rxd_d  = s_axis_tdata[1:0];
        sh_d   = {2'b00, s_axis_tdata[7:2]};
        last_d = s_axis_tlast;
        err_d  = s_axis_tlast && s_axis_tuser;
        rxer_d = s_axis_tlast && s_axis_tuser;
        uf_d   = 1'b0;
      end else begin
        rxd_d     = 2'b00;
        rxer_d    = 1'b1;
        uf_d      = 1'b1;
        tl_seen_d = 1'b0;
      end
    end

    if (start_c) begin
      state_d = ST_PREAMBLE;
      pre_d   = '0;
      speed_d = speed_100;
      crsdv_d = 1'b1;
      rxd_d   = PREAMBLE_DIBIT;
      rxer_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dib_q     <= 2'd0;
      pre_q     <= '0;
      ifg_q     <= '0;
      sh_q      <= 8'h00;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      uf_q      <= 1'b0;
      tl_seen_q <= 1'b0;
      speed_q   <= 1'b0;
      crsdv_q   <= 1'b0;
      rxd_q     <= 2'b00;
      rxer_q    <= 1'b0;
      ufl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dib_q     <= dib_d;
      pre_q     <= pre_d;
      ifg_q     <= ifg_d;
      sh_q      <= sh_d;
      last_q    <= last_d;
      err_q     <= err_d;
      uf_q      <= uf_d;
      tl_seen_q <= tl_seen_d;
      speed_q   <= speed_d;
      crsdv_q   <= crsdv_d;
      rxd_q     <= rxd_d;
      rxer_q    <= rxer_d;
      ufl_q     <= ufl_d;
    end
  end

  assign s_axis_tready  = tready_c;
  assign rmii_crsdv     = crsdv_q;
  assign rmii_rxd       = rxd_q;
  assign rmii_rxer      = rxer_q;
  assign busy           = (state_q != ST_IDLE);
  assign stat_underflow = ufl_q;

endmodule
